pipe_stall_ctrl: RTL and testbench

Parametrised pipeline stall controller for the pipelined CPU. It merges per-stage stall requests and data-bus wait status into a per-stage stall vector. It adds a post-reset hold sequence, a tracked bus-wait state, an optional bus watchdog and a saturating stall-cycle counter. It sits beside the pipeline registers, which consume `stall[i]` to freeze stage `i`.

---
 rtl/pipe_stall_ctrl_pkg.sv | 20 ++
 rtl/stall_mask_gen.sv | 24 ++
 rtl/pipe_stall_ctrl.sv | 112 +++++++++++
 tb/tb_pipe_stall_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types for the pipeline stall controller: FSM state encodings,
// statistics counter width and its saturating increment.
package pipe_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        PC_HOLD    = 2'd0,
        PC_RUN     = 2'd1,
        PC_BUSWAIT = 2'd2,
        PC_ERROR   = 2'd3
    } pc_state_e;

    localparam int STAT_W = 32;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
        if (&value)
            return value;
        return value + {{(STAT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/stall_mask_gen.sv
// Combinational stall-request merge: request k freezes stages 0..REQ_STAGE[k].
// A REQ_STAGE entry at or beyond STAGES freezes the whole pipe.
module stall_mask_gen #(
    parameter int                  STAGES    = 6,
    parameter int                  NREQ      = 2,
    parameter logic [NREQ*4-1:0]   REQ_STAGE = {4'd3, 4'd2}
) (
    input  logic [NREQ-1:0]   stallreq,
    output logic [STAGES-1:0] mask
);

    always_comb begin
        mask = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (stallreq[k]) begin
                for (int s = 0; s < STAGES; s++) begin
                    if (s <= int'(REQ_STAGE[k*4 +: 4]))
                        mask[s] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: post-reset hold, bus-wait tracking, stall statistics.
// Optional bus watchdog enabled by defining PIPE_STALL_WATCHDOG_EN.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int                  STAGES      = 6,
    parameter int                  NREQ        = 2,
    parameter logic [NREQ*4-1:0]   REQ_STAGE   = {4'd3, 4'd2},
    parameter int                  RST_HOLD    = 2,
    parameter int                  BUS_TIMEOUT = 255,
    parameter int                  WDW         = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   stallreq,
    input  logic              bus_busy,
    input  logic              bus_done,
    input  logic              stat_clr,
    output logic [STAGES-1:0] stall,
    output logic              bus_timeout,
    output logic [STAT_W-1:0] stall_cycles
);

`ifdef PIPE_STALL_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    localparam int             HCW       = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HCW-1:0] HOLD_INIT = HCW'(RST_HOLD - 1);
    localparam logic [WDW-1:0] WD_LAST   = WDW'(BUS_TIMEOUT - 1);

    pc_state_e         state_q, state_d;
    logic [HCW-1:0]    hold_q, hold_d;
    logic [WDW-1:0]    wd_q, wd_d;
    logic              timeout_q;
    logic [STAT_W-1:0] cyc_q;
    logic [STAGES-1:0] req_mask;

    stall_mask_gen #(
        .STAGES    (STAGES),
        .NREQ      (NREQ),
        .REQ_STAGE (REQ_STAGE)
    ) u_mask (
        .stallreq (stallreq),
        .mask     (req_mask)
    );

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        wd_d    = wd_q;
        stall   = '1;
        case (state_q)
            PC_HOLD: begin
                if (hold_q == '0)
                    state_d = PC_RUN;
                else
                    hold_d = hold_q - HCW'(1);
            end
            PC_RUN: begin
                // busy together with done is a finished single-cycle access
                if (bus_busy && !bus_done) begin
                    state_d = PC_BUSWAIT;
                    wd_d    = '0;
                end else begin
                    stall = req_mask;
                end
            end
            PC_BUSWAIT: begin
                if (bus_done) begin
                    stall   = req_mask;
                    state_d = PC_RUN;
                end else begin
                    wd_d = wd_q + WDW'(1);
                    if (WD_EN && (wd_q == WD_LAST))
                        state_d = PC_ERROR;
                end
            end
            default: begin
                stall = '1;
            end
        endcase
        if (!rst_n)
            stall = '1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= PC_HOLD;
            hold_q    <= HOLD_INIT;
            wd_q      <= '0;
            timeout_q <= 1'b0;
            cyc_q     <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            wd_q    <= wd_d;
            if (state_d == PC_ERROR)
                timeout_q <= 1'b1;
            if (stat_clr)
                cyc_q <= '0;
            else if (|stall)
                cyc_q <= sat_inc(cyc_q);
        end
    end

    assign bus_timeout  = WD_EN & timeout_q;
    assign stall_cycles = cyc_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed testbench for pipe_stall_ctrl: table of same-cycle mask vectors
// plus hand-written reset, bus-wait, watchdog and statistics sequences.
module tb_pipe_stall_ctrl;

`ifdef PIPE_STALL_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  stallreq;
    logic        bus_busy;
    logic        bus_done;
    logic        stat_clr;
    logic [5:0]  stall;
    logic        bus_timeout;
    logic [31:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] req;
        logic       busy;
        logic       done;
        logic [5:0] exp_stall;
    } vec_t;

    vec_t vecs[7];

    pipe_stall_ctrl #(
        .STAGES      (6),
        .NREQ        (2),
        .REQ_STAGE   ({4'd3, 4'd2}),
        .RST_HOLD    (2),
        .BUS_TIMEOUT (4),
        .WDW         (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stallreq     (stallreq),
        .bus_busy     (bus_busy),
        .bus_done     (bus_done),
        .stat_clr     (stat_clr),
        .stall        (stall),
        .bus_timeout  (bus_timeout),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_and_hold(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_rst_stall"}, 32'(stall), 32'h3F);
        tick();
        check({tag, "_rst_timeout"}, 32'(bus_timeout), 32'h0);
        check({tag, "_rst_cycles"}, stall_cycles, 32'h0);
        rst_n = 1'b1;
        #1;
        check({tag, "_hold1"}, 32'(stall), 32'h3F);
        tick();
        check({tag, "_hold2"}, 32'(stall), 32'h3F);
        tick();
        check({tag, "_run_stall"}, 32'(stall), 32'h00);
        check({tag, "_run_cycles"}, stall_cycles, 32'd2);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        vecs[0] = '{req: 2'b00, busy: 1'b0, done: 1'b0, exp_stall: 6'b000000};
        vecs[1] = '{req: 2'b01, busy: 1'b0, done: 1'b0, exp_stall: 6'b000111};
        vecs[2] = '{req: 2'b10, busy: 1'b0, done: 1'b0, exp_stall: 6'b001111};
        vecs[3] = '{req: 2'b11, busy: 1'b0, done: 1'b0, exp_stall: 6'b001111};
        vecs[4] = '{req: 2'b00, busy: 1'b1, done: 1'b1, exp_stall: 6'b000000};
        vecs[5] = '{req: 2'b10, busy: 1'b1, done: 1'b1, exp_stall: 6'b001111};
        vecs[6] = '{req: 2'b01, busy: 1'b0, done: 1'b1, exp_stall: 6'b000111};

        rst_n    = 1'b0;
        stallreq = 2'b00;
        bus_busy = 1'b0;
        bus_done = 1'b0;
        stat_clr = 1'b0;
        tick();
        reset_and_hold("init");
        tick();
        check("idle_stall", 32'(stall), 32'h00);
        check("idle_cycles", stall_cycles, 32'd2);

        // same-cycle request mask and busy+done in RUN
        for (int i = 0; i < 7; i++) begin
            stallreq = vecs[i].req;
            bus_busy = vecs[i].busy;
            bus_done = vecs[i].done;
            #1;
            check($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
            tick();
        end
        stallreq = 2'b00;
        bus_busy = 1'b0;
        bus_done = 1'b0;
        #1;
        check("after_vec_run", 32'(stall), 32'h00);
        tick();

        // bus transaction: 3 stalled cycles then done with req0
        bus_busy = 1'b1;
        stallreq = 2'b01;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bus_wait%0d", i), 32'(stall), 32'h3F);
            tick();
        end
        bus_done = 1'b1;
        #1;
        check("bus_done_stall", 32'(stall), 32'h07);
        tick();
        bus_busy = 1'b0;
        bus_done = 1'b0;
        stallreq = 2'b00;
        #1;
        check("bus_back_run", 32'(stall), 32'h00);
        check("bus_no_timeout", 32'(bus_timeout), 32'h0);
        tick();

        // done arriving in the watchdog trip cycle wins
        bus_busy = 1'b1;
        tick();
        bus_busy = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        bus_done = 1'b1;
        stallreq = 2'b10;
        #1;
        check("trip_done_stall", 32'(stall), 32'h0F);
        tick();
        bus_done = 1'b0;
        stallreq = 2'b00;
        #1;
        check("trip_done_run", 32'(stall), 32'h00);
        check("trip_done_no_err", 32'(bus_timeout), 32'h0);
        tick();

        // bus pulse with no done: watchdog trips after the 5th stalled cycle
        bus_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("wd_stall%0d", i), 32'(stall), 32'h3F);
            check($sformatf("wd_pre%0d", i), 32'(bus_timeout), 32'h0);
            tick();
            bus_busy = 1'b0;
        end
        check("wd_timeout", 32'(bus_timeout), 32'(WD));
        check("wd_stall_after", 32'(stall), 32'h3F);
        bus_done = 1'b1;
        #1;
        check("wd_done_ignored", 32'(stall), WD ? 32'h3F : 32'h00);
        tick();
        bus_done = 1'b0;
        check("wd_sticky", 32'(bus_timeout), 32'(WD));

        // reset aborts a wait (or ERROR) and restarts HOLD
        bus_busy = 1'b1;
        tick();
        bus_busy = 1'b0;
        reset_and_hold("abort");
        tick();

        // statistics clear and saturation
        stat_clr = 1'b1;
        stallreq = 2'b01;
        tick();
        check("clr_zero", stall_cycles, 32'd0);
        stat_clr = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("count_ten", stall_cycles, 32'd10);
        stat_clr = 1'b1;
        tick();
        check("clr_wins", stall_cycles, 32'd0);
        stat_clr = 1'b0;
        tick();
        check("count_one", stall_cycles, 32'd1);
        force dut.cyc_q = 32'hFFFF_FFFE;
        tick();
        release dut.cyc_q;
        tick();
        check("sat_reach", stall_cycles, 32'hFFFF_FFFF);
        tick();
        check("sat_hold", stall_cycles, 32'hFFFF_FFFF);
        stallreq = 2'b00;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
